// File: rtl/exec_stage.sv
// exec_stage: execute stage (and/or/add/xor/sub, latency 1; unsigned shift-add mul over WIDTH cycles when EXEC_MUL_EN is defined) -- ports: clk, rst; in_valid/in_ready accept in_aluc, in_a, in_b, in_rn, in_wreg; out_valid/out_ready deliver out_r, out_rn, out_wreg, out_zero, out_err; busy while multiplying
module exec_stage #(
  parameter int WIDTH = 32,
  parameter int RNW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_aluc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RNW-1:0]   in_rn,
  input  logic             in_wreg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [RNW-1:0]   out_rn,
  output logic             out_wreg,
  output logic             out_zero,
  output logic             out_err,
  output logic             busy
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic accept, mul_op, illegal;
  logic [WIDTH-1:0] res;
  assign in_ready = state == IDLE && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  always_comb begin
    res = '0;
    illegal = 1'b0;
    case (in_aluc)
      4'b0000: res = in_a & in_b;
      4'b0001: res = in_a | in_b;
      4'b0010: res = in_a + in_b;
      4'b0011: res = in_a ^ in_b;
      4'b0101: res = in_a - in_b;
      default: illegal = !mul_op;
    endcase
  end
`ifdef EXEC_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_next;
  assign mul_op = in_aluc == 4'b0110;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
  assign mul_op = 1'b0;
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_r <= '0;
      out_rn <= '0;
      out_wreg <= 1'b0;
      out_err <= 1'b0;
      out_zero <= 1'b1;
`ifdef EXEC_MUL_EN
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (state == MUL) begin
      acc <= acc_next;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        state <= IDLE;
        busy <= 1'b0;
        cnt <= '0;
        out_valid <= 1'b1;
        out_r <= acc_next;
        out_zero <= acc_next == '0;
        out_err <= 1'b0;
      end
`endif
    end else begin
      if (accept) begin
        out_rn <= in_rn;
        out_wreg <= in_wreg;
      end
`ifdef EXEC_MUL_EN
      if (accept && mul_op) begin
        state <= MUL;
        busy <= 1'b1;
        cnt <= '0;
        acc <= '0;
        mcand <= in_a;
        mplier <= in_b;
        out_valid <= 1'b0;
      end else
`endif
      if (accept) begin
        out_valid <= 1'b1;
        out_r <= res;
        out_zero <= res == '0;
        out_err <= illegal;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: self-checking bench for exec_stage with directed scenarios and a randomized scoreboard run
module tb_exec_stage;
  logic clk, rst, in_valid, in_ready, in_wreg, out_valid, out_ready, out_wreg, out_zero, out_err, busy;
  logic [3:0] in_aluc;
  logic [31:0] in_a, in_b, out_r;
  logic [4:0] in_rn, out_rn;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct packed {
    logic [31:0] r;
    logic [4:0] rn;
    logic wreg;
    logic zero;
    logic err;
  } exp_t;
  exec_stage #(.WIDTH(32), .RNW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_aluc(in_aluc),
    .in_a(in_a), .in_b(in_b), .in_rn(in_rn), .in_wreg(in_wreg), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_rn(out_rn), .out_wreg(out_wreg),
    .out_zero(out_zero), .out_err(out_err), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rn, input logic wreg);
    exp_t e;
    e.rn = rn;
    e.wreg = wreg;
    e.err = 1'b0;
    case (op)
      4'h0: e.r = a & b;
      4'h1: e.r = a | b;
      4'h2: e.r = a + b;
      4'h3: e.r = a ^ b;
      4'h5: e.r = a - b;
`ifdef EXEC_MUL_EN
      4'h6: e.r = a * b;
`endif
      default: begin
        e.r = 32'h0;
        e.err = 1'b1;
      end
    endcase
    e.zero = e.r == 32'h0;
    return e;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rn, input logic wreg);
    in_valid = 1'b1;
    in_aluc = op;
    in_a = a;
    in_b = b;
    in_rn = rn;
    in_wreg = wreg;
    step();
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    n_chk++; if (out_valid !== 1'b0 || out_r !== 32'h0 || out_zero !== 1'b1 || out_err !== 1'b0 || busy !== 1'b0) $display("FAIL reset_state: valid=%b r=%h zero=%b err=%b busy=%b want 0/0/1/0/0", out_valid, out_r, out_zero, out_err, busy); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    out_ready = 1'b0;
    issue(4'h2, 32'h1, 32'h1, 5'd9, 1'b1);
    n_chk++; if (out_valid !== 1'b1 || out_r !== 32'h2) $display("FAIL pre_reset_add: valid=%b r=%h want 1/00000002", out_valid, out_r); else n_pass++;
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_aluc = 4'h1;
    in_a = 32'hFF;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || out_r !== 32'h0 || out_rn !== 5'd0 || out_wreg !== 1'b0 || out_zero !== 1'b1) $display("FAIL reset_priority: valid=%b r=%h rn=%0d wreg=%b zero=%b want 0/0/0/0/1", out_valid, out_r, out_rn, out_wreg, out_zero); else n_pass++;
  endtask
  task automatic test_add();
    out_ready = 1'b1;
    issue(4'h2, 32'h10000011, 32'h20000022, 5'd3, 1'b1);
    n_chk++; if (out_valid !== 1'b1 || out_r !== 32'h30000033 || out_zero !== 1'b0) $display("FAIL add: valid=%b r=%h zero=%b want 1/30000033/0", out_valid, out_r, out_zero); else n_pass++;
    n_chk++; if (out_rn !== 5'd3 || out_wreg !== 1'b1 || out_err !== 1'b0) $display("FAIL add_tags: rn=%0d wreg=%b err=%b want 3/1/0", out_rn, out_wreg, out_err); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL add_consumed: valid=%b want 0", out_valid); else n_pass++;
  endtask
  task automatic test_backpressure();
    out_ready = 1'b0;
    issue(4'h3, 32'h30000033, 32'h90000099, 5'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (out_valid !== 1'b1 || out_r !== 32'hA00000AA || out_rn !== 5'd7 || in_ready !== 1'b0) $display("FAIL bp_hold_%0d: valid=%b r=%h rn=%0d in_ready=%b want 1/a00000aa/7/0", i, out_valid, out_r, out_rn, in_ready); else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1 || out_r !== 32'hA00000AA) $display("FAIL bp_release: in_ready=%b r=%h want 1/a00000aa", in_ready, out_r); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_consumed: valid=%b want 0", out_valid); else n_pass++;
  endtask
  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [31:0] b [4];
    a[0] = 32'h90000099;
    b[0] = 32'h80000088;
    for (int i = 1; i < 4; i++) begin
      a[i] = $urandom;
      b[i] = $urandom;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_aluc = 4'h5;
      in_a = a[i];
      in_b = b[i];
      in_rn = 5'(i);
      in_wreg = 1'b1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready); else n_pass++;
      step();
      n_chk++; if (out_valid !== 1'b1 || out_r !== a[i] - b[i] || out_rn !== 5'(i)) $display("FAIL b2b_result_%0d: valid=%b r=%h rn=%0d want 1/%h/%0d", i, out_valid, out_r, out_rn, a[i] - b[i], i); else n_pass++;
    end
    in_valid = 1'b0;
    n_chk++; if (a[0] - b[0] !== 32'h10000011) $display("FAIL b2b_first_model: got %h want 10000011", a[0] - b[0]); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: valid=%b want 0", out_valid); else n_pass++;
  endtask
  task automatic test_illegal();
    out_ready = 1'b1;
    issue(4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd5, 1'b1);
    n_chk++; if (out_valid !== 1'b1 || out_r !== 32'h0 || out_err !== 1'b1 || out_zero !== 1'b1) $display("FAIL illegal_f: valid=%b r=%h err=%b zero=%b want 1/0/1/1", out_valid, out_r, out_err, out_zero); else n_pass++;
    issue(4'h2, 32'h5, 32'h6, 5'd1, 1'b0);
    n_chk++; if (out_err !== 1'b0 || out_r !== 32'hB) $display("FAIL err_clears: err=%b r=%h want 0/0000000b", out_err, out_r); else n_pass++;
`ifndef EXEC_MUL_EN
    issue(4'h6, 32'h7, 32'h6, 5'd2, 1'b1);
    n_chk++; if (out_valid !== 1'b1 || out_r !== 32'h0 || out_err !== 1'b1 || out_zero !== 1'b1 || busy !== 1'b0) $display("FAIL illegal_mul: valid=%b r=%h err=%b zero=%b busy=%b want 1/0/1/1/0", out_valid, out_r, out_err, out_zero, busy); else n_pass++;
    step();
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL illegal_mul_idle: busy=%b in_ready=%b valid=%b want 0/1/0", busy, in_ready, out_valid); else n_pass++;
`endif
    step();
  endtask
`ifdef EXEC_MUL_EN
  task automatic test_mul();
    int n, nb, nr;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [31:0] w [2];
    a[0] = 32'h7; b[0] = 32'h6; w[0] = 32'd42;
    a[1] = 32'hFFFFFFFF; b[1] = 32'h2; w[1] = 32'hFFFFFFFE;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(4'h6, a[k], b[k], 5'd11, 1'b1);
      n = 0; nb = 0; nr = 0;
      while (!out_valid && n < 100) begin
        if (busy) nb++;
        if (!in_ready) nr++;
        step();
        n++;
      end
      n_chk++; if (out_valid !== 1'b1) $display("FAIL mul_%0d_timeout: no result after %0d cycles", k, n); else n_pass++;
      n_chk++; if (nb != 32 || nr != 32) $display("FAIL mul_%0d_cycles: busy=%0d in_ready_low=%0d want 32/32", k, nb, nr); else n_pass++;
      n_chk++; if (out_r !== w[k] || out_err !== 1'b0 || out_zero !== 1'b0 || busy !== 1'b0 || out_rn !== 5'd11) $display("FAIL mul_%0d_result: r=%h err=%b zero=%b busy=%b rn=%0d want %h/0/0/0/11", k, out_r, out_err, out_zero, busy, out_rn, w[k]); else n_pass++;
    end
    step();
  endtask
  task automatic test_mul_reset();
    int seen;
    out_ready = 1'b1;
    issue(4'h6, 32'h1234, 32'h5678, 5'd4, 1'b1);
    repeat (9) step();
    n_chk++; if (busy !== 1'b1) $display("FAIL mulrst_busy_before: got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL mulrst_after: valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready); else n_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    n_chk++; if (seen != 0) $display("FAIL mulrst_no_result: valid seen %0d cycles want 0", seen); else n_pass++;
  endtask
`endif
  task automatic test_random(input int cycles);
    logic [3:0] ops [8];
    exp_t q[$];
    exp_t e, got;
    bit hold, drain;
    logic [31:0] held_r;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'hF, 4'h4};
    for (int c = 0; c < cycles + 300; c++) begin
      drain = c >= cycles;
      if (drain && q.size() == 0) break;
      in_valid = !drain && $urandom_range(0, 2) != 0;
      in_aluc = ops[$urandom_range(0, 7)];
      in_a = $urandom;
      in_b = $urandom_range(0, 3) == 0 ? in_a : $urandom;
      in_rn = 5'($urandom);
      in_wreg = 1'($urandom);
      out_ready = drain || $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        got.r = out_r; got.rn = out_rn; got.wreg = out_wreg; got.zero = out_zero; got.err = out_err;
        if (q.size() == 0) begin
          n_chk++; $display("FAIL rand_unexpected: result %h with empty scoreboard", out_r);
        end else begin
          e = q.pop_front();
          n_chk++; if (got !== e) $display("FAIL rand_result: got r=%h rn=%0d w=%b z=%b e=%b want r=%h rn=%0d w=%b z=%b e=%b", got.r, got.rn, got.wreg, got.zero, got.err, e.r, e.rn, e.wreg, e.zero, e.err); else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_aluc, in_a, in_b, in_rn, in_wreg));
      hold = out_valid && !out_ready;
      held_r = out_r;
      step();
      if (hold) begin
        n_chk++; if (out_valid !== 1'b1 || out_r !== held_r) $display("FAIL rand_hold: valid=%b r=%h want 1/%h", out_valid, out_r, held_r); else n_pass++;
      end
    end
    in_valid = 1'b0;
    n_chk++; if (q.size() != 0) $display("FAIL rand_drain: %0d results outstanding want 0", q.size()); else n_pass++;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_aluc = 4'h0;
    in_a = '0;
    in_b = '0;
    in_rn = '0;
    in_wreg = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_illegal();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_reset();
`endif
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width in bits, legal values 8 to 64.
REQ-002 SHALL have parameter RNW, default 5: destination register number width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered operation this cycle.
REQ-007 SHALL have port in_aluc, input, 4 bits: operation code (0000 and, 0001 or, 0010 add, 0011 xor, 0101 sub, 0110 mul).
REQ-008 SHALL have ports in_a and in_b, input, WIDTH bits each: the two operands.
REQ-009 SHALL have ports in_rn (input, RNW bits) and in_wreg (input, 1 bit): destination register number and write enable, carried unchanged to the output.
REQ-010 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): result handshake.
REQ-011 SHALL have ports out_r (output, WIDTH bits), out_rn (output, RNW bits) and out_wreg (output, 1 bit): result and passed-through tags.
REQ-012 SHALL have ports out_zero (output, 1 bit, set when out_r is 0) and out_err (output, 1 bit, set when the opcode was illegal).
REQ-013 SHALL have port busy, output, 1 bit: a multiply is in progress.

Function
REQ-014 SHALL transfer an operation in when in_valid and in_ready are both high at a rising edge; a result leaves when out_valid and out_ready are both high.
REQ-015 SHALL drive in_ready = (state IDLE) and (out_valid low, or out_ready high); in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL implement a two-state FSM:
- IDLE to MUL when a mul is accepted.
- MUL to IDLE at the edge the final iteration completes.
REQ-017 SHALL register the result of and/or/add/xor/sub at the acceptance edge, so out_valid is high in the following cycle (latency 1).
REQ-018 SHALL compute add and sub modulo 2^WIDTH, with no overflow or carry output.
REQ-019 SHALL compute mul as an unsigned shift-add, one bit per cycle, over WIDTH iterations:
- out_r holds the low WIDTH bits of the product.
- out_valid rises after the WIDTH-th edge following acceptance.
- busy is high during those WIDTH cycles.
REQ-020 SHALL treat any other opcode as illegal: result 0 with latency 1, out_err 1 and out_zero 1; the state does not change.
REQ-021 SHALL hold out_r, out_rn, out_wreg, out_zero and out_err stable while out_valid is high and out_ready is low.
REQ-022 SHALL clear out_valid at the consuming edge unless a new latency-1 result is loaded at the same edge, giving full throughput of one result per cycle.
REQ-023 SHALL keep in_ready low throughout MUL, ignoring in_valid; out_valid is low throughout MUL.

Reset
REQ-024 SHALL, when rst is high at a rising edge, force:
- state to IDLE and the iteration counter to 0;
- out_valid, out_r, out_rn, out_wreg, out_err and busy to 0, and out_zero to 1.
REQ-025 SHALL, when reset occurs mid-multiply, discard the partial product with no result emitted; in_ready is 1 in the first cycle after reset.
REQ-026 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-027 SHALL use macro EXEC_MUL_EN:
- Defined: the multiplier, MUL state, counter and busy logic are compiled in.
- Undefined: opcode 0110 is illegal per REQ-020, busy is tied to 0 and the FSM stays IDLE.

Verification
REQ-028 SHALL cover add: WIDTH=32, a=0x10000011, b=0x20000022 -> next cycle out_valid=1, out_r=0x30000033, out_zero=0.
REQ-029 SHALL cover back-pressure: out_ready=0 for 3 cycles after an xor of 0x30000033 and 0x90000099 -> out_r=0xA00000AA held stable and in_ready=0; out_ready=1 -> consumed, with in_ready=1 in that same cycle.
REQ-030 SHALL cover multiply: EXEC_MUL_EN defined, mul 7 by 6 -> busy high 32 cycles, in_ready low 32 cycles, then out_r=42; 0xFFFFFFFF by 2 -> out_r=0xFFFFFFFE.
REQ-031 SHALL cover reset mid-multiply: rst asserted 10 cycles into a mul -> no out_valid, busy=0 and in_ready=1 in the next cycle.
REQ-032 SHALL cover illegal opcodes:
- opcode 1111 -> out_r=0, out_err=1, out_zero=1, latency 1;
- EXEC_MUL_EN undefined, opcode 0110 -> same response, busy stays 0.
REQ-033 SHALL cover throughput: back-to-back sub ops with out_ready=1 -> one result per cycle; 0x90000099 - 0x80000088 gives 0x10000011.
